port_operand_stager: RTL
========================

// Module: port_operand_stager
//
// PURPOSE
//  Sequential stage that sits directly upstream of a single-input/single-output
//  int instance (input int a, output int b). It buffers 32-bit operands in a
//  small FIFO and applies a constant offset. It drives each operand onto the
//  instance input and holds it stable for a fixed settle time, then samples the
//  instance output. The operand/result pair is returned over a valid/ready
//  channel, so a combinational or pipelined instance can be exercised one
//  operand at a time.
//
// PARAMETERS
//  DEPTH   4   operand FIFO entries; power of two, >= 2
//  OFFSET  2   signed 32-bit constant added to each operand before driving x_a
//  SETTLE  1   cycles x_a is held before x_b is sampled; >= 1
//
// PORTS
//  clk        in   1                 clock, all state updates on rising edge
//  rst_n      in   1                 synchronous reset, active low
//  in_valid   in   1                 operand offered
//  in_ready   out  1                 FIFO can accept (count < DEPTH)
//  in_data    in   32                signed operand
//  x_a        out  32                drive to instance port a (registered)
//  x_b        in   32                instance port b
//  out_valid  out  1                 result pair available
//  out_ready  in   1                 consumer accepts result
//  out_arg    out  32                value that was driven on x_a
//  out_data   out  32                x_b sampled for that operand
//  count      out  $clog2(DEPTH)+1   FIFO occupancy
//  busy       out  1                 FSM not in IDLE
//
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): FIFO emptied, FSM->IDLE, x_a/out_arg/out_data=0,
//    out_valid=0, busy=0, count=0. in_ready is 1 after reset. Reset mid-operation
//    discards queued operands and any pending result; no partial output.
//  - Push: in_valid && in_ready at edge. in_ready is derived from the current
//    count only. When full it stays 0 even if a pop happens in the same cycle.
//  - Simultaneous push and pop: count is unchanged, and the data order is
//    preserved.
//  - FSM states: IDLE, SETTLE, EMIT.
//    IDLE: if count>0, pop the head. x_a <= head + OFFSET (32-bit two's
//      complement, wraps, no saturation). Load settle counter = SETTLE-1 and go
//      to SETTLE.
//    SETTLE: x_a held. If counter==0, out_data <= x_b, out_arg <= x_a, go to
//      EMIT. Otherwise decrement.
//    EMIT: out_valid=1. out_arg/out_data are stable until the handshake. On
//      out_ready, go to IDLE.
//  - x_a keeps its last driven value between operands. It never glitches to 0
//    except on reset.
//  - Latency: push at edge t into an empty FIFO with the FSM in IDLE gives x_a
//    at edge t+1 and out_valid high after edge t+1+SETTLE.
//  - Throughput: one result per SETTLE+2 cycles with out_ready held at 1.
//  - Capacity: with out_ready=0, DEPTH+1 operands are accepted (one in the FSM
//    plus DEPTH queued) before in_ready=0.
//  - Pointer wrap: the read and write pointers wrap modulo DEPTH. Full and empty
//    are distinguished by count.
//
// TESTING
//  1. Assert reset 3 cycles -> x_a=0, out_valid=0, count=0, in_ready=1, busy=0.
//  2. Model b=3*a with 1-cycle delay, SETTLE=2; push 5 -> x_a=7,
//     out_arg=7, out_data=21, out_valid exactly 3 cycles after push edge.
//  3. out_ready=0, offer 1..8 continuously -> 5 accepted, in_ready=0,
//     count=4; release out_ready -> results 3..7 in order, no loss/dup.
//  4. Push 0x7FFFFFFF with OFFSET=2 -> x_a=0x80000001; push 0xFFFFFFFE
//     -> x_a=0x00000000.
//  5. Reset during SETTLE with 3 queued -> next cycle count=0, out_valid=0,
//     x_a=0; a fresh push of 1 yields out_arg=3.
//  6. out_ready=1, stream 1..16 with in_valid=1 and identity model (SETTLE=1)
//     -> out_data=3..18 in order, one result every 3 cycles; the FIFO
//     pointers wrap at least 3 times.

Source files
------------

// File: rtl/port_operand_stager.sv
// port_operand_stager: queues operands, drives them offset onto an instance input,
// waits a settle time, then returns the operand/result pair over valid/ready.
module port_operand_stager #(
  parameter int DEPTH = 4,
  parameter logic signed [31:0] OFFSET = 32'sd2,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  output logic [31:0]              x_a,
  input  logic [31:0]              x_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_arg,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EMIT} state_t;
  state_t state;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [SW-1:0] cnt;
  logic push, pop;
  assign in_ready = count < (AW+1)'(DEPTH);
  assign push = in_valid && in_ready;
  assign pop = state == S_IDLE && count != '0;
  assign busy = state != S_IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      cnt <= '0;
      x_a <= '0;
      out_arg <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= in_data;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        S_IDLE: if (pop) begin
          x_a <= mem[rp] + OFFSET;
          cnt <= SW'(SETTLE - 1);
          state <= S_SETTLE;
        end
        S_SETTLE: if (cnt == '0) begin
          out_data <= x_b;
          out_arg <= x_a;
          out_valid <= 1'b1;
          state <= S_EMIT;
        end else cnt <= cnt - SW'(1);
        S_EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
